// File: rtl/equiv_sweep_checker_pkg.sv
// rtl/equiv_sweep_checker_pkg.sv - shared state encoding and width helper for the sweep checker
package equiv_sweep_checker_pkg;

  // Two-bit binary state encoding: IDLE=0, WAIT=1, CHECK=2, DONE=3.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sweep_vec_counter.sv
// rtl/sweep_vec_counter.sv - swept input vector register with clear, increment and last-vector flag
module sweep_vec_counter #(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [N_IN-1:0] vec_o,
  output logic            is_last_o
);

  logic [N_IN-1:0] vec_q, vec_d;

  // Clear wins over increment so a restart always begins at vector zero.
  always_comb begin
    vec_d = vec_q;
    if (clr_i) begin
      vec_d = '0;
    end else if (inc_i) begin
      vec_d = vec_q + N_IN'(1);
    end
  end

  // Vector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec_o     = vec_q;
  assign is_last_o = &vec_q;

endmodule

// File: rtl/equiv_sweep_checker.sv
// rtl/equiv_sweep_checker.sv - sweeps all input vectors and compares reference against rewritten function
module equiv_sweep_checker
  import equiv_sweep_checker_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = N_IN + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic             ref_in,
  input  logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [N_IN-1:0]  first_mism,
  output logic             first_valid
);

  localparam int               SET_W    = cnt_width(SETTLE);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  first_q, first_d;
  logic             fv_q, fv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             vec_clr, vec_inc, is_last;

  sweep_vec_counter #(.N_IN(N_IN)) u_vec (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (vec_clr),
    .inc_i     (vec_inc),
    .vec_o     (vec_out),
    .is_last_o (is_last)
  );

  // Next-state, settle timing, compare and result update for each phase of the sweep.
  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    fv_d    = fv_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    vec_clr = 1'b0;
    vec_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          vec_clr = 1'b1;
          set_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          fv_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (set_q == SET_LAST) begin
          state_d = ST_CHECK;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      ST_CHECK: begin
        if (ref_in != dut_in) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!fv_q) begin
            first_d = vec_out;
            fv_d    = 1'b1;
          end
        end
        if (is_last) begin
          // Verdict uses the count including this final vector's compare.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
        end else begin
          state_d = ST_WAIT;
          vec_inc = 1'b1;
          set_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset abandons any sweep in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign mism_cnt    = cnt_q;
  assign first_mism  = first_q;
  assign first_valid = fv_q;

endmodule
